// File: rtl/deserializer_1to2_pkg.sv
// Shared definitions for the alternate-edge 2:1 link: lane-phase state encoding.
package deserializer_1to2_pkg;

  typedef enum logic {
    ST_EXP2 = 1'b0,
    ST_EXP1 = 1'b1
  } state_t;

endpackage

// File: rtl/deserializer_1to2.sv
// Rebuilds data2/data1 word pairs from an alternating-lane word stream and
// presents them through a single valid/ready output register.
module deserializer_1to2
  import deserializer_1to2_pkg::*;
#(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [W-1:0]     data1,
  output logic [W-1:0]     data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             phase,
  output logic             align_err,
  output logic             overflow,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] pair_cnt
);

  state_t       state, state_nxt;
  logic [W-1:0] hold;
  logic         hold_load;
  logic         pair_done;
  logic         align_set;
  logic         pair_load;
  logic         pair_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EXP2;
    else        state <= state_nxt;
  end

  // A sync word in EXP1 restarts the pair with this word as the new data2.
  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    pair_done = 1'b0;
    align_set = 1'b0;
    if (din_valid) begin
      case (state)
        ST_EXP2: begin
          hold_load = 1'b1;
          state_nxt = ST_EXP1;
        end
        ST_EXP1: begin
          if (sync) begin
            hold_load = 1'b1;
            align_set = 1'b1;
          end else begin
            pair_done = 1'b1;
            state_nxt = ST_EXP2;
          end
        end
        default: state_nxt = ST_EXP2;
      endcase
    end
  end

  assign pair_load = pair_done && (!out_valid || out_ready);
  assign pair_drop = pair_done && out_valid && !out_ready;
  assign phase     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold <= '0;
    else if (hold_load) hold <= din;
  end

  // Output stage: accept and reload may happen on the same edge without a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data1     <= '0;
      data2     <= '0;
      out_valid <= 1'b0;
      pair_cnt  <= '0;
    end else if (pair_load) begin
      data2     <= hold;
      data1     <= din;
      out_valid <= 1'b1;
      pair_cnt  <= pair_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      align_err <= align_set;
      if (pair_drop)      overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deserializer_1to2.sv
// Directed bench for deserializer_1to2 (W=4), with a CNT_W=2 twin for counter wrap.
module tb_deserializer_1to2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       din_valid;
  logic       sync;
  logic       out_ready;
  logic       clr_flags;

  logic [3:0] data1, data2, data1_b, data2_b;
  logic       out_valid, phase, align_err, overflow;
  logic       out_valid_b, phase_b, align_err_b, overflow_b;
  logic [7:0] pair_cnt;
  logic [1:0] pair_cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  deserializer_1to2 #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .data1(data1), .data2(data2), .out_valid(out_valid), .out_ready(out_ready),
    .phase(phase), .align_err(align_err), .overflow(overflow),
    .clr_flags(clr_flags), .pair_cnt(pair_cnt)
  );

  deserializer_1to2 #(.W(4), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .data1(data1_b), .data2(data2_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .phase(phase_b), .align_err(align_err_b), .overflow(overflow_b),
    .clr_flags(clr_flags), .pair_cnt(pair_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [3:0] d, input logic s);
    din       = d;
    din_valid = 1'b1;
    sync      = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; din = '0; din_valid = 1'b0; sync = 1'b0;
    out_ready = 1'b1; clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", {data2, data1}, 0);
    chk("rst_flags", {phase, align_err, overflow}, 0);
    chk("rst_cnt", pair_cnt, 0);
    reset = 1'b1;

    // Basic pairing A,B,C,D with consumer always ready
    idle();
    word(4'hA, 1'b0);
    chk("s1_phase_a", phase, 1);
    chk("s1_valid_a", out_valid, 0);
    word(4'hB, 1'b0);
    chk("s1_pair_ab", {out_valid, data2, data1}, {1'b1, 4'hA, 4'hB});
    chk("s1_phase_b", phase, 0);
    word(4'hC, 1'b0);
    chk("s1_valid_c", out_valid, 0);
    chk("s1_phase_c", phase, 1);
    word(4'hD, 1'b0);
    chk("s1_pair_cd", {out_valid, data2, data1}, {1'b1, 4'hC, 4'hD});
    chk("s1_cnt", pair_cnt, 2);
    chk("s1_phase_d", phase, 0);
    idle();
    chk("s1_valid_drop", out_valid, 0);
    chk("s1_hold_data", {data2, data1}, {4'hC, 4'hD});

    // Re-alignment on sync while expecting data1
    do_reset();
    word(4'h3, 1'b1);
    chk("s2_align_3", align_err, 0);
    word(4'h5, 1'b1);
    chk("s2_align_5", align_err, 1);
    chk("s2_phase_5", phase, 1);
    chk("s2_valid_5", out_valid, 0);
    word(4'h6, 1'b0);
    chk("s2_align_6", align_err, 0);
    chk("s2_pair_56", {out_valid, data2, data1}, {1'b1, 4'h5, 4'h6});
    chk("s2_cnt", pair_cnt, 1);

    // Overflow when consumer stalls, then accept and clear
    do_reset();
    out_ready = 1'b0;
    word(4'h1, 1'b0);
    word(4'h2, 1'b0);
    word(4'h3, 1'b0);
    chk("s3_no_ovf_yet", overflow, 0);
    word(4'h4, 1'b0);
    chk("s3_ovf", overflow, 1);
    chk("s3_pair_kept", {out_valid, data2, data1}, {1'b1, 4'h1, 4'h2});
    chk("s3_cnt", pair_cnt, 1);
    chk("s3_phase", phase, 0);
    out_ready = 1'b1;
    idle();
    chk("s3_accept", out_valid, 0);
    chk("s3_ovf_sticky", overflow, 1);
    clr_flags = 1'b1;
    idle();
    clr_flags = 1'b0;
    chk("s3_clr", overflow, 0);

    // Overflow set beats clr_flags in the same cycle
    out_ready = 1'b0;
    word(4'h7, 1'b0);
    word(4'h8, 1'b0);
    word(4'h9, 1'b0);
    clr_flags = 1'b1;
    word(4'hA, 1'b0);
    clr_flags = 1'b0;
    chk("s3_set_wins", overflow, 1);
    chk("s3_pair_78", {data2, data1}, {4'h7, 4'h8});
    clr_flags = 1'b1;
    idle();
    clr_flags = 1'b0;

    // Simultaneous accept and load: no bubble, no overflow
    word(4'hB, 1'b0);
    out_ready = 1'b1;
    word(4'hC, 1'b0);
    chk("s4_pair_bc", {out_valid, data2, data1}, {1'b1, 4'hB, 4'hC});
    chk("s4_no_ovf", overflow, 0);
    chk("s4_cnt", pair_cnt, 3);

    // Asynchronous reset mid-pair discards the held word
    idle();
    word(4'h9, 1'b0);
    chk("s5_phase_pre", phase, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("s5_async_out", {out_valid, data2, data1, phase, overflow, align_err}, 0);
    chk("s5_async_cnt", pair_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    word(4'h1, 1'b0);
    word(4'h2, 1'b0);
    chk("s5_pair_12", {out_valid, data2, data1}, {1'b1, 4'h1, 4'h2});

    // Counter wrap on the CNT_W=2 instance
    do_reset();
    out_ready = 1'b1;
    word(4'h1, 1'b0); word(4'h2, 1'b0); chk("s6_cnt1", pair_cnt_b, 1);
    word(4'h3, 1'b0); word(4'h4, 1'b0); chk("s6_cnt2", pair_cnt_b, 2);
    word(4'h5, 1'b0); word(4'h6, 1'b0); chk("s6_cnt3", pair_cnt_b, 3);
    word(4'h7, 1'b0); word(4'h8, 1'b0); chk("s6_cnt0", pair_cnt_b, 0);
    word(4'h9, 1'b0); word(4'hA, 1'b0); chk("s6_cnt1b", pair_cnt_b, 1);
    chk("s6_cnt_wide", pair_cnt, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
